// File: rtl/vram_port_arbiter_if.sv
// Request/response bundle linking the three VRAM requesters, the arbiter and the VRAM macro.
// slave = arbiter side, master = requester/VRAM side.
interface vram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned NB_COL = 4
);
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wrdata;
    logic [NB_COL-1:0] p0_wrbytesel;
    logic              p0_ack;
    logic              p0_rvalid;

    logic              p1_req;
    logic [ADDR_W-1:0] p1_addr;
    logic              p1_ack;
    logic              p1_rvalid;

    logic              p2_req;
    logic [ADDR_W-1:0] p2_addr;
    logic              p2_ack;
    logic              p2_rvalid;

    logic [31:0]       rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wrdata;
    logic [NB_COL-1:0] ram_wrbytesel;
    logic [31:0]       ram_rddata;

    modport slave (
        input  p0_req, p0_addr, p0_wrdata, p0_wrbytesel,
        input  p1_req, p1_addr,
        input  p2_req, p2_addr,
        input  ram_rddata,
        output p0_ack, p0_rvalid, p1_ack, p1_rvalid, p2_ack, p2_rvalid,
        output rdata, ram_addr, ram_wrdata, ram_wrbytesel
    );

    modport master (
        output p0_req, p0_addr, p0_wrdata, p0_wrbytesel,
        output p1_req, p1_addr,
        output p2_req, p2_addr,
        output ram_rddata,
        input  p0_ack, p0_rvalid, p1_ack, p1_rvalid, p2_ack, p2_rvalid,
        input  rdata, ram_addr, ram_wrdata, ram_wrbytesel
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Three-port arbiter in front of a single-port, write-first, byte-write VRAM (1-cycle read latency).
// Optional CPU starvation guard enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_port_arbiter #(
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned NB_COL         = 4,
    parameter int unsigned CPU_MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    vram_port_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;

    logic              p12_req;
    logic              win1;
    logic              force_rr;
    logic              gnt0;
    logic              gnt1;
    logic              gnt2;
    logic              p0_rd;

    // 0: port 1 preferred, 1: port 2 preferred
    logic              rr_ptr_q;
    logic              rr_ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wrdata_q;
    logic [2:0]        rvalid_q;
    logic [2:0]        rvalid_d;

    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wrdata_c;
    logic [NB_COL-1:0] ram_wrbytesel_c;

    assign p12_req = bus.p1_req | bus.p2_req;

    // Round-robin winner among ports 1/2; a lone requester wins regardless of the pointer.
    assign win1 = bus.p1_req & (~bus.p2_req | ~rr_ptr_q);

    assign gnt0 = ~rst & bus.p0_req & ~force_rr;
    assign gnt1 = ~rst & ~gnt0 & win1;
    assign gnt2 = ~rst & ~gnt0 & bus.p2_req & ~win1;

    assign p0_rd = gnt0 & (bus.p0_wrbytesel == '0);

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(CPU_MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // After CPU_MAX_STREAK back-to-back CPU wins against a waiting fetch port, hand one slot over.
    assign force_rr = p12_req & (streak_q == STREAK_W'(CPU_MAX_STREAK));

    always_comb begin
        streak_d = streak_q;
        if (!p12_req || force_rr) begin
            streak_d = '0;
        end else if (gnt0) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_streak_cfg;

    assign force_rr          = 1'b0;
    assign unused_streak_cfg = (CPU_MAX_STREAK == 0);
`endif

    // Pointer moves to the port that was not just served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt1) begin
            rr_ptr_d = 1'b1;
        end else if (gnt2) begin
            rr_ptr_d = 1'b0;
        end
    end

    // Steer the granted port onto the RAM bus; address and data hold while idle.
    always_comb begin
        ram_addr_c      = addr_q;
        ram_wrdata_c    = wrdata_q;
        ram_wrbytesel_c = '0;
        if (rst) begin
            ram_addr_c   = '0;
            ram_wrdata_c = '0;
        end else if (gnt0) begin
            ram_addr_c      = bus.p0_addr;
            ram_wrdata_c    = bus.p0_wrdata;
            ram_wrbytesel_c = bus.p0_wrbytesel;
        end else if (gnt1) begin
            ram_addr_c = bus.p1_addr;
        end else if (gnt2) begin
            ram_addr_c = bus.p2_addr;
        end
    end

    assign rvalid_d = {gnt2, gnt1, p0_rd};

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            rvalid_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= ram_addr_c;
            wrdata_q <= ram_wrdata_c;
            rvalid_q <= rvalid_d;
        end
    end

    // Strobes are masked during reset so a read issued just before reset never reports.
    assign bus.p0_ack        = gnt0;
    assign bus.p1_ack        = gnt1;
    assign bus.p2_ack        = gnt2;
    assign bus.p0_rvalid     = rvalid_q[0] & ~rst;
    assign bus.p1_rvalid     = rvalid_q[1] & ~rst;
    assign bus.p2_rvalid     = rvalid_q[2] & ~rst;
    assign bus.rdata         = bus.ram_rddata;
    assign bus.ram_addr      = ram_addr_c;
    assign bus.ram_wrdata    = ram_wrdata_c;
    assign bus.ram_wrbytesel = ram_wrbytesel_c;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios then random traffic,
// all compared against a transaction-level reference model and shadow memory.
module tb_vram_port_arbiter;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned NB_COL     = 4;
    localparam int unsigned MAX_STREAK = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .NB_COL(NB_COL)) bus ();

    vram_port_arbiter #(
        .ADDR_W(ADDR_W), .NB_COL(NB_COL), .CPU_MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // VRAM model: write-first, byte lanes, 1-cycle read latency
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_next;
    always_comb begin
        ram_next = ram[bus.ram_addr];
        for (int b = 0; b < NB_COL; b++)
            if (bus.ram_wrbytesel[b]) ram_next[8*b +: 8] = bus.ram_wrdata[8*b +: 8];
    end
    always @(posedge clk) begin
        ram[bus.ram_addr] <= ram_next;
        bus.ram_rddata    <= ram_next;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0]       ref_mem [DEPTH];
    int                last12;
    int                streak;
    logic [ADDR_W-1:0] hold_addr;
    logic [2:0]        exp_rv;
    logic [31:0]       exp_rd;
    logic [2:0]        last_ack;
    logic [2:0]        last_rv;
    logic [NB_COL-1:0] last_wbs;

    function automatic int pick(input logic r, input logic q0, input logic q1, input logic q2,
                                input int last, input int strk);
        bit guard_hit;
        if (r) return -1;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        guard_hit = (q1 || q2) && (strk == MAX_STREAK);
`else
        guard_hit = 1'b0;
        if (strk < 0) guard_hit = 1'b1;
`endif
        if (q0 && !guard_hit) return 0;
        if (q1 && q2) return (last == 1) ? 2 : 1;
        if (q1) return 1;
        if (q2) return 2;
        return -1;
    endfunction

    // One clock: sample outputs mid-cycle, check them, advance the model, cross the edge.
    task automatic step();
        int                g;
        logic              q1;
        logic              q2;
        logic [2:0]        ack_exp;
        logic [ADDR_W-1:0] addr_e;
        logic [NB_COL-1:0] wbs_e;
        #2;
        q1 = bus.p1_req;
        q2 = bus.p2_req;
        g  = pick(rst, bus.p0_req, q1, q2, last12, streak);
        ack_exp  = (g < 0) ? 3'b000 : 3'(1 << g);
        last_ack = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
        last_rv  = {bus.p2_rvalid, bus.p1_rvalid, bus.p0_rvalid};
        last_wbs = bus.ram_wrbytesel;
        check_eq("ack", 64'(last_ack), 64'(ack_exp));
        check_eq("rvalid", 64'(last_rv), 64'(rst ? 3'b000 : exp_rv));
        if (!rst && exp_rv != 3'b000) check_eq("rdata", 64'(bus.rdata), 64'(exp_rd));

        wbs_e = '0;
        case (g)
            0: begin addr_e = bus.p0_addr; wbs_e = bus.p0_wrbytesel; end
            1: addr_e = bus.p1_addr;
            2: addr_e = bus.p2_addr;
            default: addr_e = rst ? '0 : hold_addr;
        endcase
        check_eq("ram_addr", 64'(bus.ram_addr), 64'(addr_e));
        check_eq("ram_wrbytesel", 64'(bus.ram_wrbytesel), 64'(wbs_e));
        if (g == 0 && wbs_e != '0) check_eq("ram_wrdata", 64'(bus.ram_wrdata), 64'(bus.p0_wrdata));

        exp_rv = 3'b000;
        if (g == 0 && wbs_e != '0) begin
            for (int b = 0; b < NB_COL; b++)
                if (wbs_e[b]) ref_mem[addr_e][8*b +: 8] = bus.p0_wrdata[8*b +: 8];
        end else if (g >= 0) begin
            exp_rv[g] = 1'b1;
            exp_rd    = ref_mem[addr_e];
        end
        if (rst) begin
            hold_addr = '0;
            streak    = 0;
            last12    = 2;
        end else begin
            if (g >= 0) hold_addr = addr_e;
            if (!(q1 || q2)) streak = 0;
            else if (streak == MAX_STREAK) streak = 0;
            else if (g == 0) streak++;
            if (g == 1) last12 = 1;
            else if (g == 2) last12 = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.p0_req       = 1'b0;
        bus.p0_addr      = '0;
        bus.p0_wrdata    = '0;
        bus.p0_wrbytesel = '0;
        bus.p1_req       = 1'b0;
        bus.p1_addr      = '0;
        bus.p2_req       = 1'b0;
        bus.p2_addr      = '0;
    endtask

    logic [2:0] pat [10];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'(i) * 32'h01010101 ^ 32'h5A5AC3C3;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5AC3C3;
        end
        ram[16]     = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        ram[4]      = 32'h11223344; ref_mem[4]  = 32'h11223344;
        last12 = 2; streak = 0; hold_addr = '0; exp_rv = '0; exp_rd = '0;
        last_ack = '0; last_rv = '0; last_wbs = '0;
        bus.ram_rddata = '0;
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        step();
        step();
        check_eq("reset_ram_addr", 64'(bus.ram_addr), 64'd0);
        check_eq("reset_acks", 64'(last_ack), 64'd0);
        rst = 1'b0;

        // CPU word read
        bus.p0_req = 1'b1; bus.p0_addr = 15'h0010;
        step();
        check_eq("tp1_ack", 64'(last_ack), 64'b001);
        idle();
        check_eq("tp1_rvalid", 64'({bus.p2_rvalid, bus.p1_rvalid, bus.p0_rvalid}), 64'b001);
        check_eq("tp1_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        step();

        // Byte write then back-to-back read of the same word
        bus.p0_req = 1'b1; bus.p0_addr = 15'h0004; bus.p0_wrdata = 32'h000000AA; bus.p0_wrbytesel = 4'b0001;
        step();
        bus.p0_wrdata = '0; bus.p0_wrbytesel = '0;
        check_eq("tp2_no_rvalid_after_write", 64'(bus.p0_rvalid), 64'd0);
        step();
        idle();
        check_eq("tp2_rdata", 64'(bus.rdata), 64'h112233AA);
        step();

        // Ports 1/2 alternate starting with port 1
        bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.p1_addr = 15'(32 + i); bus.p2_addr = 15'(64 + i);
            step();
            check_eq("tp3_alternate", 64'(last_ack), 64'((i % 2 == 0) ? 3'b010 : 3'b100));
        end
        idle();
        step();

        // All three request for 10 cycles after a fresh reset
`ifdef VRAM_ARB_STARVE_GUARD_EN
        pat = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
`else
        pat = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        rst = 1'b1; step(); rst = 1'b0;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        bus.p1_addr = 15'h0100; bus.p2_addr = 15'h0200;
        for (int i = 0; i < 10; i++) begin
            bus.p0_addr = 15'(i);
            step();
            check_eq("tp4_grant", 64'(last_ack), 64'(pat[i]));
        end
        idle();
        step();

        // Reset right after a port-1 read ack
        bus.p1_req = 1'b1; bus.p1_addr = 15'h0033;
        step();
        check_eq("tp5_ack", 64'(last_ack), 64'b010);
        idle();
        rst = 1'b1;
        step();
        check_eq("tp5_rvalid_n1", 64'(last_rv), 64'd0);
        rst = 1'b0;
        step();
        check_eq("tp5_rvalid_n2", 64'(last_rv), 64'd0);
        bus.p1_req = 1'b1; bus.p2_req = 1'b1; bus.p1_addr = 15'h0007; bus.p2_addr = 15'h0008;
        step();
        check_eq("tp5_p1_first", 64'(last_ack), 64'b010);
        idle();

        // Write strobe present only in the ack cycle, no rvalid afterwards
        bus.p0_req = 1'b1; bus.p0_addr = 15'h0005; bus.p0_wrdata = 32'hCAFEF00D; bus.p0_wrbytesel = 4'b1010;
        step();
        check_eq("tp6_wbs_ack", 64'(last_wbs), 64'b1010);
        idle();
        step();
        check_eq("tp6_wbs_after", 64'(last_wbs), 64'd0);
        check_eq("tp6_no_p0_rvalid", 64'(last_rv[0]), 64'd0);

        // Random traffic with legal withdrawals and occasional resets
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            if (!bus.p0_req || last_ack[0]) begin
                bus.p0_req       = ($urandom_range(0, 99) < 45);
                bus.p0_addr      = ADDR_W'($urandom_range(0, 15));
                bus.p0_wrdata    = $urandom;
                bus.p0_wrbytesel = ($urandom_range(0, 1) == 1) ? NB_COL'($urandom) : '0;
            end else if ($urandom_range(0, 99) < 5) begin
                bus.p0_req = 1'b0;
            end
            if (!bus.p1_req || last_ack[1]) begin
                bus.p1_req  = ($urandom_range(0, 99) < 55);
                bus.p1_addr = ADDR_W'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 5) begin
                bus.p1_req = 1'b0;
            end
            if (!bus.p2_req || last_ack[2]) begin
                bus.p2_req  = ($urandom_range(0, 99) < 55);
                bus.p2_addr = ADDR_W'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 5) begin
                bus.p2_req = 1'b0;
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
